// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a RAM with independent read and write ports.
// Read and write ports are scheduled separately; read data returns one cycle after the grant.
module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_a,
    input  logic                  wr_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  wr_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_aw,
    output logic [DATA_WIDTH-1:0] ram_x,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_ar,
    input  logic [DATA_WIDTH-1:0] ram_y
);

    // Round-robin pointers (0 = A has priority) and read-return tracking.
    logic                  wptr;
    logic                  rptr;
    logic                  rd_pend;
    logic                  rd_own;
    logic [ADDR_WIDTH-1:0] aw_q;
    logic [ADDR_WIDTH-1:0] ar_q;
    logic [DATA_WIDTH-1:0] x_q;

    logic wcand_a, wcand_b, rcand_a, rcand_b;
    logic wgnt_a, wgnt_b, rgnt_a, rgnt_b;
    logic rd_gnt;
    logic pend_live;

    // Candidate selection and per-port grants; nothing is granted while in reset.
    always_comb begin
        wcand_a = ~rst & req_a &  wr_a;
        wcand_b = ~rst & req_b &  wr_b;
        rcand_a = ~rst & req_a & ~wr_a;
        rcand_b = ~rst & req_b & ~wr_b;

        wgnt_a  = wcand_a & (~wcand_b | ~wptr);
        wgnt_b  = wcand_b & (~wcand_a |  wptr);
        rgnt_a  = rcand_a & (~rcand_b | ~rptr);
        rgnt_b  = rcand_b & (~rcand_a |  rptr);

        rd_gnt  = rgnt_a | rgnt_b;
        gnt_a   = wgnt_a | rgnt_a;
        gnt_b   = wgnt_b | rgnt_b;
    end

    // RAM port drive; addresses and write data hold their last value when idle.
    always_comb begin
        ram_we = wgnt_a | wgnt_b;
        ram_aw = aw_q;
        ram_x  = x_q;
        if (wgnt_a) begin
            ram_aw = addr_a;
            ram_x  = wdata_a;
        end else if (wgnt_b) begin
            ram_aw = addr_b;
            ram_x  = wdata_b;
        end

        ram_ar = ar_q;
        if (rgnt_a) begin
            ram_ar = addr_a;
        end else if (rgnt_b) begin
            ram_ar = addr_b;
        end

        // re stays high through the data cycle so the RAM keeps driving y.
        pend_live = rd_pend & ~rst;
        ram_re    = rd_gnt | pend_live;
    end

    // Read return steering; the non-owner sees zero data.
    always_comb begin
        rvalid_a = pend_live & ~rd_own;
        rvalid_b = pend_live &  rd_own;
        rdata_a  = '0;
        rdata_b  = '0;
        if (rvalid_a) begin
            rdata_a = ram_y;
        end
        if (rvalid_b) begin
            rdata_b = ram_y;
        end
    end

    // State update: pointers flip only on contested grants so the loser wins next.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            rd_pend <= 1'b0;
            rd_own  <= 1'b0;
            aw_q    <= '0;
            ar_q    <= '0;
            x_q     <= '0;
        end else begin
            if (wcand_a & wcand_b) begin
                wptr <= ~wptr;
            end
            if (rcand_a & rcand_b) begin
                rptr <= ~rptr;
            end
            rd_pend <= rd_gnt;
            if (rd_gnt) begin
                rd_own <= rgnt_b;
            end
            aw_q <= ram_aw;
            ar_q <= ram_ar;
            x_q  <= ram_x;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    logic          clk;
    logic          rst;
    logic          req_a, wr_a, req_b, wr_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_aw, ram_ar;
    logic [DW-1:0] ram_x, ram_y;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_we(ram_we), .ram_aw(ram_aw), .ram_x(ram_x),
        .ram_re(ram_re), .ram_ar(ram_ar), .ram_y(ram_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write at posedge, registered read returning pre-write contents.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) mem[ram_aw] <= ram_x;
        if (ram_re) ram_y <= mem[ram_ar];
    end

    typedef struct packed {
        logic          own;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       sb [$];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    logic          exp_rptr;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_a(input logic rq, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        req_a = rq; wr_a = wr; addr_a = ad; wdata_a = wd;
    endtask

    task automatic set_b(input logic rq, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        req_b = rq; wr_b = wr; addr_b = ad; wdata_b = wd;
    endtask

    task automatic push_rd(input logic own, input logic [AW-1:0] ad);
        rd_exp_t e;
        e.own  = own;
        e.data = exp_mem[ad];
        sb.push_back(e);
    endtask

    // Compare read-return outputs against the entry due this cycle (if any).
    task automatic check_rd();
        rd_exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid_a", 32'(rvalid_a), 32'(!e.own));
            chk("rvalid_b", 32'(rvalid_b), 32'(e.own));
            chk("rdata_a", 32'(rdata_a), e.own ? 32'(0) : 32'(e.data));
            chk("rdata_b", 32'(rdata_b), e.own ? 32'(e.data) : 32'(0));
        end else begin
            chk("idle_rvalid_a", 32'(rvalid_a), 32'(0));
            chk("idle_rvalid_b", 32'(rvalid_b), 32'(0));
            chk("idle_rdata_a", 32'(rdata_a), 32'(0));
            chk("idle_rdata_b", 32'(rdata_b), 32'(0));
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        check_rd();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] pre_addr [3];
    logic [DW-1:0] pre_data [3];

    initial begin
        pre_addr[0] = 16'h0001; pre_data[0] = 8'h11;
        pre_addr[1] = 16'h0002; pre_data[1] = 8'h22;
        pre_addr[2] = 16'h0020; pre_data[2] = 8'h33;

        // Reset with both requesters contending for the write port.
        rst = 1'b1;
        set_a(1'b1, 1'b1, 16'h0030, 8'hAA);
        set_b(1'b1, 1'b1, 16'h0031, 8'hBB);
        repeat (2) begin
            begin_cycle();
            chk("rst_gnt_a", 32'(gnt_a), 32'(0));
            chk("rst_gnt_b", 32'(gnt_b), 32'(0));
            chk("rst_ram_we", 32'(ram_we), 32'(0));
            chk("rst_ram_re", 32'(ram_re), 32'(0));
            end_cycle();
        end
        rst = 1'b0;
        exp_rptr = 1'b0;
        begin_cycle();
        chk("rel_gnt_a", 32'(gnt_a), 32'(1));
        chk("rel_gnt_b", 32'(gnt_b), 32'(0));
        chk("rel_ram_we", 32'(ram_we), 32'(1));
        chk("rel_ram_aw", 32'(ram_aw), 32'(16'h0030));
        chk("rel_ram_x", 32'(ram_x), 32'(8'hAA));
        exp_mem[16'h0030] = 8'hAA;
        end_cycle();
        set_a(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        chk("loser_gnt_b", 32'(gnt_b), 32'(1));
        chk("loser_ram_aw", 32'(ram_aw), 32'(16'h0031));
        chk("loser_ram_x", 32'(ram_x), 32'(8'hBB));
        exp_mem[16'h0031] = 8'hBB;
        end_cycle();

        // Preload contents through requester B.
        for (int i = 0; i < 3; i++) begin
            set_b(1'b1, 1'b1, pre_addr[i], pre_data[i]);
            begin_cycle();
            chk("pre_gnt_b", 32'(gnt_b), 32'(1));
            chk("pre_ram_aw", 32'(ram_aw), 32'(pre_addr[i]));
            exp_mem[pre_addr[i]] = pre_data[i];
            end_cycle();
        end
        set_b(1'b0, 1'b0, 16'h0000, 8'h00);

        // A writes then reads back the same word.
        set_a(1'b1, 1'b1, 16'h0010, 8'h5A);
        begin_cycle();
        chk("t2_wr_gnt_a", 32'(gnt_a), 32'(1));
        chk("t2_ram_x", 32'(ram_x), 32'(8'h5A));
        exp_mem[16'h0010] = 8'h5A;
        end_cycle();
        set_a(1'b1, 1'b0, 16'h0010, 8'h00);
        begin_cycle();
        chk("t2_rd_gnt_a", 32'(gnt_a), 32'(1));
        chk("t2_ram_re", 32'(ram_re), 32'(1));
        chk("t2_ram_ar", 32'(ram_ar), 32'(16'h0010));
        chk("t2_ram_we", 32'(ram_we), 32'(0));
        push_rd(1'b0, 16'h0010);
        end_cycle();
        set_a(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        chk("t2_pend_re", 32'(ram_re), 32'(1));
        chk("t2_aw_hold", 32'(ram_aw), 32'(16'h0010));
        end_cycle();

        // Both read continuously: grants alternate, one result per cycle.
        set_a(1'b1, 1'b0, 16'h0001, 8'h00);
        set_b(1'b1, 1'b0, 16'h0002, 8'h00);
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            chk("t3_gnt_a", 32'(gnt_a), 32'(!exp_rptr));
            chk("t3_gnt_b", 32'(gnt_b), 32'(exp_rptr));
            chk("t3_ram_re", 32'(ram_re), 32'(1));
            chk("t3_ram_ar", 32'(ram_ar), exp_rptr ? 32'(16'h0002) : 32'(16'h0001));
            push_rd(exp_rptr, exp_rptr ? 16'h0002 : 16'h0001);
            exp_rptr = ~exp_rptr;
            end_cycle();
        end
        set_a(1'b0, 1'b0, 16'h0000, 8'h00);
        set_b(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        chk("t3_drain_re", 32'(ram_re), 32'(1));
        end_cycle();

        // Same-cycle write by A and read by B of one address, then B rereads.
        set_a(1'b1, 1'b1, 16'h0020, 8'h77);
        set_b(1'b1, 1'b0, 16'h0020, 8'h00);
        begin_cycle();
        chk("t4_gnt_a", 32'(gnt_a), 32'(1));
        chk("t4_gnt_b", 32'(gnt_b), 32'(1));
        chk("t4_ram_we", 32'(ram_we), 32'(1));
        chk("t4_ram_re", 32'(ram_re), 32'(1));
        push_rd(1'b1, 16'h0020);
        exp_mem[16'h0020] = 8'h77;
        end_cycle();
        set_a(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        chk("t4_reread_gnt_b", 32'(gnt_b), 32'(1));
        push_rd(1'b1, 16'h0020);
        end_cycle();
        set_b(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        end_cycle();

        // Lone read: re high for exactly two cycles with a stable address.
        set_a(1'b1, 1'b0, 16'h0002, 8'h00);
        begin_cycle();
        chk("t5_re_c0", 32'(ram_re), 32'(1));
        chk("t5_ar_c0", 32'(ram_ar), 32'(16'h0002));
        push_rd(1'b0, 16'h0002);
        end_cycle();
        set_a(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        chk("t5_re_c1", 32'(ram_re), 32'(1));
        chk("t5_ar_c1", 32'(ram_ar), 32'(16'h0002));
        end_cycle();
        begin_cycle();
        chk("t5_re_c2", 32'(ram_re), 32'(0));
        end_cycle();

        // Read granted, then reset next cycle: no return, pointers restart at A.
        set_a(1'b1, 1'b0, 16'h0001, 8'h00);
        set_b(1'b1, 1'b0, 16'h0002, 8'h00);
        begin_cycle();
        chk("t6_gnt_a", 32'(gnt_a), 32'(!exp_rptr));
        push_rd(exp_rptr, exp_rptr ? 16'h0002 : 16'h0001);
        end_cycle();
        rst = 1'b1;
        sb.delete();
        begin_cycle();
        chk("t6_rst_gnt_a", 32'(gnt_a), 32'(0));
        chk("t6_rst_gnt_b", 32'(gnt_b), 32'(0));
        chk("t6_rst_re", 32'(ram_re), 32'(0));
        end_cycle();
        rst = 1'b0;
        exp_rptr = 1'b0;
        begin_cycle();
        chk("t6_post_gnt_a", 32'(gnt_a), 32'(1));
        chk("t6_post_gnt_b", 32'(gnt_b), 32'(0));
        chk("t6_post_aw", 32'(ram_aw), 32'(0));
        chk("t6_post_x", 32'(ram_x), 32'(0));
        push_rd(1'b0, 16'h0001);
        end_cycle();
        set_a(1'b1, 1'b1, 16'h0040, 8'h44);
        set_b(1'b1, 1'b1, 16'h0041, 8'h55);
        begin_cycle();
        chk("t6_wr_gnt_a", 32'(gnt_a), 32'(1));
        chk("t6_wr_gnt_b", 32'(gnt_b), 32'(0));
        exp_mem[16'h0040] = 8'h44;
        end_cycle();
        set_a(1'b0, 1'b0, 16'h0000, 8'h00);
        set_b(1'b0, 1'b0, 16'h0000, 8'h00);
        begin_cycle();
        end_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
